// File: rtl/mem_responder_if.sv
// CPU memory-port and side-loader signal bundle for mem_responder.
// master = CPU/bench side, slave = responder side.
interface mem_responder_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] memdata;
    logic             memready;
    logic             busy;
    logic             load_we;
    logic [WIDTH-1:0] load_adr;
    logic [WIDTH-1:0] load_data;
    logic             load_ack;
    logic             protocol_err;

    modport master (
        output adr, writedata, memread, memwrite, load_we, load_adr, load_data,
        input  memdata, memready, busy, load_ack, protocol_err
    );

    modport slave (
        input  adr, writedata, memread, memwrite, load_we, load_adr, load_data,
        output memdata, memready, busy, load_ack, protocol_err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: byte read/write requests answered with a one-cycle memready pulse
// after WAIT_CYCLES wait states; a side loader may write the array while idle.
module mem_responder #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           i_clk,
    input  logic           i_reset,
    mem_responder_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [WIDTH-1:0] r_mem [2**WIDTH];
    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_adr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_memdata;
    logic             r_is_write;
    logic             r_load_ack;
    logic             r_perr;

    logic             w_idle;
    logic             w_load;
    logic             w_accept;
    logic             w_to_resp;
    logic             w_rd_is_read;
    logic             w_commit;
    logic [WIDTH-1:0] w_rd_adr;

    always_comb begin
        w_idle   = (r_state == S_IDLE);
        w_load   = w_idle && bus.load_we;
        w_accept = w_idle && !bus.load_we && (bus.memread || bus.memwrite);
        // RESP is entered either straight from accept (no wait states) or when WAIT expires;
        // read data is captured on that same edge so it is valid for the whole RESP cycle.
        w_to_resp    = (w_accept && (WAIT_CYCLES == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd0));
        w_rd_is_read = (r_state == S_WAIT) ? !r_is_write : !bus.memwrite;
        w_rd_adr     = (r_state == S_WAIT) ? r_adr : bus.adr;
        w_commit     = (r_state == S_RESP) && r_is_write;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_memdata  <= '0;
            r_load_ack <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_load_ack <= w_load;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_adr      <= bus.adr;
                        r_wdata    <= bus.writedata;
                        r_is_write <= bus.memwrite;
                        r_cnt      <= CNT_INIT;
                        r_state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                        if (bus.memread && bus.memwrite) begin
                            r_perr <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_to_resp && w_rd_is_read) begin
                r_memdata <= r_mem[w_rd_adr];
            end
        end
    end

    // Array is never cleared; a reset edge suppresses any write, aborting a pending commit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            if (w_load) begin
                r_mem[bus.load_adr] <= bus.load_data;
            end else if (w_commit) begin
                r_mem[r_adr] <= r_wdata;
            end
        end
    end

    assign bus.memdata      = r_memdata;
    assign bus.memready     = (r_state == S_RESP);
    assign bus.busy         = !w_idle;
    assign bus.load_ack     = r_load_ack;
    assign bus.protocol_err = r_perr;
endmodule
